// File: rtl/latency_memory_pkg.sv
// latency_memory_pkg: shared state type, counter width and address helper for latency_memory
package latency_memory_pkg;
  localparam int LM_CNT_W = 32;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} lm_state_t;
  function automatic logic [127:0] lm_word_index(input logic [127:0] address, input int lane_bits);
    return address >> lane_bits;
  endfunction
endpackage

// File: rtl/lm_byte_ram.sv
// lm_byte_ram: word array with per-lane synchronous write and synchronous read
module lm_byte_ram #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH_WORDS = 4096,
  parameter int RW          = 12,
  parameter     INIT_FILE   = ""
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    re,
  input  logic [DATA_WIDTH/8-1:0] we,
  input  logic [RW-1:0]           idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   q
);
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  initial for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
  always_ff @(posedge clk)
    for (int i = 0; i < DATA_WIDTH/8; i++)
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= re ? mem[idx] : '0;
endmodule

// File: rtl/latency_memory.sv
// latency_memory: single-port memory responder with configurable latency, abort, error and access counters
module latency_memory
  import latency_memory_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 4,
  parameter     INIT_FILE   = ""
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byte_enable,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    resp,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic [LM_CNT_W-1:0]     read_count,
  output logic [LM_CNT_W-1:0]     write_count
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int LB = $clog2(BW);
  localparam int IW = ADDR_WIDTH - LB;
  localparam int RW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  if (LATENCY < 1) begin : g_bad_latency
    $error("LATENCY must be at least 1");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (longint'(DEPTH_WORDS) > (64'd1 << IW)) begin : g_bad_depth
    $error("DEPTH_WORDS exceeds the addressable word range");
  end
  lm_state_t      state;
  logic [CW-1:0]  cnt;
  logic           op_wr;
  logic [127:0]   idx_w;
  logic           both, any, go, op_w, acc_err;
  assign idx_w   = lm_word_index(128'(address), LB);
  assign both    = read & write;
  assign any     = read | write;
  // go marks the edge that enters RESP; the access itself happens on that edge
  assign go      = (state == IDLE && (both || (any && LATENCY == 1))) ||
                   (state == WAIT && any && cnt <= CW'(1));
  assign op_w    = state == IDLE ? write : op_wr;
  assign acc_err = both || idx_w >= 128'(DEPTH_WORDS);
  lm_byte_ram #(
    .DATA_WIDTH(DATA_WIDTH), .DEPTH_WORDS(DEPTH_WORDS), .RW(RW), .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk(clk), .rst_n(rst_n),
    .re(go && !acc_err && !op_w),
    .we({BW{go && !acc_err && op_w}} & byte_enable),
    .idx(idx_w[RW-1:0]), .wdata(wdata), .q(rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_wr       <= 1'b0;
      resp        <= 1'b0;
      err         <= 1'b0;
      read_count  <= '0;
      write_count <= '0;
    end else begin
      resp <= go;
      err  <= go && acc_err;
      case (state)
        IDLE: begin
          if (any) op_wr <= write;
          if (go) state <= RESP;
          else if (any) begin
            state <= WAIT;
            cnt   <= CW'(LATENCY - 1);
          end
        end
        WAIT: begin
          if (!any) state <= IDLE;
          else if (go) begin
            state <= RESP;
            cnt   <= '0;
          end else cnt <= cnt - CW'(1);
        end
        default: begin
          state <= IDLE;
          if (!err && op_wr) write_count <= write_count + 1'b1;
          if (!err && !op_wr) read_count <= read_count + 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_latency_memory.sv
// tb_latency_memory: table-driven scoreboard bench for latency_memory at two configurations
module tb_latency_memory;
  typedef struct packed {
    logic        r;
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    int          exp_rc;
    int          exp_wc;
  } vec_t;
  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk = 0, rst_n = 0;
  logic read_a = 0, write_a = 0, resp_a, err_a;
  logic [1:0] be_a = 0;
  logic [15:0] addr_a = 0, wd_a = 0, rd_a;
  logic [31:0] rc_a, wc_a;
  logic read_b = 0, write_b = 0, resp_b, err_b;
  logic [3:0] be_b = 0;
  logic [15:0] addr_b = 0;
  logic [31:0] wd_b = 0, rd_b, rc_b, wc_b;

  int total = 0, bad = 0, cyc = 0;
  exp_t q_a[$], q_b[$];
  vec_t ta[11], tb[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  latency_memory u_dut_a (
    .clk(clk), .rst_n(rst_n), .read(read_a), .write(write_a), .byte_enable(be_a),
    .address(addr_a), .wdata(wd_a), .resp(resp_a), .rdata(rd_a), .err(err_a),
    .read_count(rc_a), .write_count(wc_a)
  );
  latency_memory #(.DATA_WIDTH(32), .LATENCY(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .read(read_b), .write(write_b), .byte_enable(be_b),
    .address(addr_b), .wdata(wd_b), .resp(resp_b), .rdata(rd_b), .err(err_b),
    .read_count(rc_b), .write_count(wc_b)
  );

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resp_a) begin
      if (q_a.size() == 0) check("sb_a_unexpected_resp", 1, 0);
      else begin
        e = q_a.pop_front();
        check("rdata_a", 64'(rd_a), 64'(e.rd));
        check("err_a", 64'(err_a), 64'(e.err));
      end
    end
    if (resp_b) begin
      if (q_b.size() == 0) check("sb_b_unexpected_resp", 1, 0);
      else begin
        e = q_b.pop_front();
        check("rdata_b", 64'(rd_b), 64'(e.rd));
        check("err_b", 64'(err_b), 64'(e.err));
      end
    end
  end

  // caller is at a negedge; returns at a negedge one cycle after the resp cycle
  task automatic run(input bit b, input vec_t v, output int t0);
    int k = 0;
    if (b) q_b.push_back('{v.exp_rd, v.exp_err});
    else q_a.push_back('{v.exp_rd, v.exp_err});
    t0 = cyc;
    if (b) begin
      read_b = v.r; write_b = v.w; addr_b = v.a; wd_b = v.d; be_b = v.be;
    end else begin
      read_a = v.r; write_a = v.w; addr_a = v.a; wd_a = v.d[15:0]; be_a = v.be[1:0];
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (b ? resp_b : resp_a) begin
        k = i;
        break;
      end
    end
    check(b ? "latency_b" : "latency_a", 64'(k), 64'(v.lat));
    read_a = 0; write_a = 0; read_b = 0; write_b = 0;
    @(negedge clk);
    check(b ? "resp_pulse_b" : "resp_pulse_a", 64'(b ? resp_b : resp_a), 0);
    check(b ? "read_count_b" : "read_count_a", 64'(b ? rc_b : rc_a), 64'(v.exp_rc));
    check(b ? "write_count_b" : "write_count_a", 64'(b ? wc_b : wc_a), 64'(v.exp_wc));
  endtask

  initial begin
    int t0, tp;
    bit saw;
    ta[0]  = '{1'b0, 1'b1, 16'h0010, 32'hBEEF, 4'h3, 32'h0,    1'b0, 4, 0, 1};
    ta[1]  = '{1'b1, 1'b0, 16'h0010, 32'h0,    4'h3, 32'hBEEF, 1'b0, 4, 1, 1};
    ta[2]  = '{1'b0, 1'b1, 16'h0020, 32'h1234, 4'h3, 32'h0,    1'b0, 4, 1, 2};
    ta[3]  = '{1'b0, 1'b1, 16'h0020, 32'hAB00, 4'h2, 32'h0,    1'b0, 4, 1, 3};
    ta[4]  = '{1'b1, 1'b0, 16'h0021, 32'h0,    4'h0, 32'hAB34, 1'b0, 4, 2, 3};
    ta[5]  = '{1'b1, 1'b1, 16'h0030, 32'h5555, 4'h3, 32'h0,    1'b1, 1, 2, 3};
    ta[6]  = '{1'b1, 1'b0, 16'h0030, 32'h0,    4'h0, 32'h0,    1'b0, 4, 3, 3};
    ta[7]  = '{1'b1, 1'b0, 16'h2000, 32'h0,    4'h0, 32'h0,    1'b1, 4, 3, 3};
    ta[8]  = '{1'b0, 1'b1, 16'h2000, 32'h5A5A, 4'h3, 32'h0,    1'b1, 4, 3, 3};
    ta[9]  = '{1'b0, 1'b1, 16'h0040, 32'h12FF, 4'h1, 32'h0,    1'b0, 4, 3, 4};
    ta[10] = '{1'b1, 1'b0, 16'h0040, 32'h0,    4'h0, 32'h00FF, 1'b0, 4, 4, 4};
    tb[0]  = '{1'b0, 1'b1, 16'h0000, 32'h11223344, 4'hF, 32'h0,        1'b0, 1, 0, 1};
    tb[1]  = '{1'b0, 1'b1, 16'h0004, 32'h55667788, 4'hF, 32'h0,        1'b0, 1, 0, 2};
    tb[2]  = '{1'b0, 1'b1, 16'h0008, 32'h99AABBCC, 4'h5, 32'h0,        1'b0, 1, 0, 3};
    tb[3]  = '{1'b1, 1'b0, 16'h0000, 32'h0,        4'h0, 32'h11223344, 1'b0, 1, 1, 3};
    tb[4]  = '{1'b1, 1'b0, 16'h0004, 32'h0,        4'h0, 32'h55667788, 1'b0, 1, 2, 3};
    tb[5]  = '{1'b1, 1'b0, 16'h0008, 32'h0,        4'h0, 32'h00AA00CC, 1'b0, 1, 3, 3};

    repeat (3) @(negedge clk);
    check("reset_resp_a", 64'(resp_a), 0);
    check("reset_err_a", 64'(err_a), 0);
    check("reset_rdata_a", 64'(rd_a), 0);
    check("reset_rc_a", 64'(rc_a), 0);
    check("reset_wc_a", 64'(wc_a), 0);
    check("reset_resp_b", 64'(resp_b), 0);
    check("reset_rc_b", 64'(rc_b), 0);
    rst_n = 1;
    @(negedge clk);

    foreach (ta[i]) run(0, ta[i], t0);

    tp = 0;
    foreach (tb[i]) begin
      run(1, tb[i], t0);
      if (i >= 4) check("spacing_b", 64'(t0 - tp), 2);
      tp = t0;
    end

    // abort: write dropped after two WAIT cycles must leave no trace
    write_a = 1; addr_a = 16'h0010; wd_a = 16'h1111; be_a = 2'b11;
    repeat (2) @(negedge clk);
    write_a = 0;
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      saw |= resp_a;
    end
    check("abort_no_resp", 64'(saw), 0);
    run(0, '{1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 32'hBEEF, 1'b0, 4, 5, 4}, t0);

    // reset during WAIT of a write: access lost, counters cleared
    write_a = 1; addr_a = 16'h0010; wd_a = 16'h2222; be_a = 2'b11;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    check("rst_resp_a", 64'(resp_a), 0);
    check("rst_err_a", 64'(err_a), 0);
    check("rst_rc_a", 64'(rc_a), 0);
    check("rst_wc_a", 64'(wc_a), 0);
    write_a = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run(0, '{1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 32'hBEEF, 1'b0, 4, 1, 0}, t0);

    repeat (2) @(negedge clk);
    check("sb_a_drained", 64'(q_a.size()), 0);
    check("sb_b_drained", 64'(q_b.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
